fifo_sync_lvl: RTL and testbench



---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_mem_sp.sv | 45 ++++
 rtl/fifo_sync_lvl.sv | 127 ++++++++++++
 tb/tb_fifo_sync_lvl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the level-reporting synchronous FIFO.
// Level width function and parameter-legality checks.
package fifo_pkg;

    // Occupancy counter needs one extra bit to represent "full".
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_ok(input int depth,
                                     input int af,
                                     input int ae);
        return is_pow2(depth) && (depth >= 4) &&
               (af >= 1) && (af <= depth) &&
               (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem_sp.sv
// Simple dual-port storage: one write port, one read port, one clock.
// Ports: clk, rst (clears read register only), we/waddr/wdata, re/raddr/rdata.
// FIFO_SYNC_FWFT_EN: asynchronous read instead of registered read.
module fifo_mem_sp #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    assign rdata = mem_q[raddr];
`else
    logic [DW-1:0] rdata_q;

    // Read-before-write: on a full-FIFO read+write both hit the
    // same address and the old head word must come out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/fifo_sync_lvl.sv
// Single-clock FIFO with occupancy level, almost-full/empty thresholds,
// sticky overflow/underflow flags and output-valid. FWFT: FIFO_SYNC_FWFT_EN.
module fifo_sync_lvl
    import fifo_pkg::*;
#(
    parameter int data_wdt  = 16,
    parameter int fifo_deth = 16,
    parameter int af_thresh = 12,
    parameter int ae_thresh = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             data_in_val,
    input  logic signed [data_wdt-1:0]       data_in,
    input  logic                             data_req,
    output logic signed [data_wdt-1:0]       data_out,
    output logic                             data_out_val,
    output logic                             full,
    output logic                             empty,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic [lvl_w(fifo_deth)-1:0]      level,
    input  logic                             err_clr,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int AW = $clog2(fifo_deth);
    localparam int LW = lvl_w(fifo_deth);
    localparam logic [LW-1:0] DEPTH_L = LW'(fifo_deth);
    localparam logic [LW-1:0] AF_L    = LW'(af_thresh);
    localparam logic [LW-1:0] AE_L    = LW'(ae_thresh);

    if (!params_ok(fifo_deth, af_thresh, ae_thresh)) begin : g_bad_params
        $error("fifo_sync_lvl: illegal depth or threshold parameters");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, empty_q, af_q, ae_q;
    logic          ov_q, ov_d, un_q, un_d;
    logic          rd_acc, wr_acc;
    logic [data_wdt-1:0] rdata;

    always_comb begin
        rd_acc   = data_req & ~empty_q;
        // A full FIFO still takes a write when a read frees a slot.
        wr_acc   = data_in_val & (~full_q | rd_acc);
        wr_ptr_d = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d = rd_ptr_q + AW'(rd_acc);
        level_d  = level_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Set beats clear when both occur in one cycle.
        ov_d = (data_in_val & ~wr_acc) | (ov_q & ~err_clr);
        un_d = (data_req & empty_q) | (un_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ov_q     <= 1'b0;
            un_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == DEPTH_L);
            empty_q  <= (level_d == '0);
            af_q     <= (level_d >= AF_L);
            ae_q     <= (level_d <= AE_L);
            ov_q     <= ov_d;
            un_q     <= un_d;
        end
    end

    fifo_mem_sp #(
        .DW    (data_wdt),
        .DEPTH (fifo_deth),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

`ifdef FIFO_SYNC_FWFT_EN
    assign data_out_val = ~empty_q;
`else
    logic dval_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dval_q <= 1'b0;
        end else begin
            dval_q <= rd_acc;
        end
    end

    assign data_out_val = dval_q;
`endif

    assign data_out     = rdata;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign level        = level_q;
    assign overflow     = ov_q;
    assign underflow    = un_q;

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// Self-checking bench for fifo_sync_lvl against a queue-based model.
// Builds for either read mode (FIFO_SYNC_FWFT_EN).
module tb_fifo_sync_lvl;

    localparam int DW = 16;
    localparam int D  = 16;
    localparam int AF = 12;
    localparam int AE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          data_in_val;
    logic [DW-1:0] data_in;
    logic          data_req;
    logic [DW-1:0] data_out;
    logic          data_out_val;
    logic          full, empty, almost_full, almost_empty;
    logic [4:0]    level;
    logic          err_clr;
    logic          overflow, underflow;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq[$];
    logic          m_ov, m_un, m_dv;
    logic [DW-1:0] m_dout;

    always #5 clk = ~clk;

    fifo_sync_lvl #(
        .data_wdt  (DW),
        .fifo_deth (D),
        .af_thresh (AF),
        .ae_thresh (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in_val  (data_in_val),
        .data_in      (data_in),
        .data_req     (data_req),
        .data_out     (data_out),
        .data_out_val (data_out_val),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = mq.size();
        chk("level", 32'(level), 32'(n));
        chk("full", 32'(full), 32'(n == D));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
`ifdef FIFO_SYNC_FWFT_EN
        chk("data_out_val", 32'(data_out_val), 32'(n > 0));
        if (n > 0) chk("data_out", 32'(data_out), 32'(mq[0]));
`else
        chk("data_out_val", 32'(data_out_val), 32'(m_dv));
        chk("data_out", 32'(data_out), 32'(m_dout));
`endif
    endtask

    // One clock: drive at negedge, model the edge, check 1ns after it.
    task automatic step(input bit wv, input logic [DW-1:0] wd,
                        input bit rq, input bit ec, input bit rs);
        bit rd, wr;
        @(negedge clk);
        data_in_val = wv;
        data_in     = wd;
        data_req    = rq;
        err_clr     = ec;
        rst         = rs;
        rd = rq && (mq.size() > 0);
        wr = wv && ((mq.size() < D) || rd);
        @(posedge clk);
        #1;
        if (rs) begin
            mq.delete();
            m_ov = 0; m_un = 0; m_dv = 0; m_dout = '0;
        end else begin
            m_ov = (wv && !wr) ? 1'b1 : (ec ? 1'b0 : m_ov);
            m_un = (rq && mq.size() == 0) ? 1'b1 : (ec ? 1'b0 : m_un);
            m_dv = rd;
            if (rd) m_dout = mq.pop_front();
            if (wr) mq.push_back(wd);
        end
        check_state();
    endtask

    initial begin
        rst = 1; data_in_val = 0; data_in = '0; data_req = 0; err_clr = 0;
        m_ov = 0; m_un = 0; m_dv = 0; m_dout = '0;

        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 0);

        for (int i = 0; i < 16; i++) step(1, DW'(i), 0, 0, 0);
        step(1, 16'd16, 0, 0, 0);

        for (int i = 0; i < 17; i++) step(0, '0, 1, 0, 0);
        step(0, '0, 0, 1, 0);

        for (int i = 0; i < 16; i++) step(1, DW'(16'h100 + i), 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, DW'(16'h200 + i), 1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, '0, 1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) step(1, DW'($urandom), 0, 0, 0);
            else step(0, '0, 1, 0, 0);
        end

        for (int i = 0; i < 16; i++) step(1, DW'($urandom), 0, 0, 0);
        step(1, 16'hdead, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        step(1, 16'hbeef, 0, 1, 0);
        step(0, '0, 0, 1, 0);

        for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 0);
        step(1, 16'h5555, 0, 0, 1);
        step(1, 16'h1234, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 0, 0);

        step(1, 16'h7777, 1, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 100) < 55, DW'($urandom),
                 ($urandom % 100) < 45, ($urandom % 100) < 5,
                 ($urandom % 200) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
